// File: rtl/game_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the board-game sequencer:
//   - 4-bit engine opcodes (OP_*) carried on eng_op
//   - button bit positions inside the 5-bit button vector
//   - FSM state enumeration
//   - helpers: coordinate width, state-to-opcode map, modular player add
// -----------------------------------------------------------------------------
package game_pkg;

    localparam logic [3:0] OP_DRAW_BOARD  = 4'd0;
    localparam logic [3:0] OP_INIT_PIECES = 4'd1;
    localparam logic [3:0] OP_DRAW_CURSOR = 4'd2;
    localparam logic [3:0] OP_CHECK       = 4'd3;
    localparam logic [3:0] OP_PLACE       = 4'd4;
    localparam logic [3:0] OP_FLIP        = 4'd5;
    localparam logic [3:0] OP_SCORE       = 4'd6;
    localparam logic [3:0] OP_HASTURN     = 4'd7;
    localparam logic [3:0] OP_UNHIGHLIGHT = 4'd8;
    localparam logic [3:0] OP_CLEAR       = 4'd9;

    // Button vector layout: {enter, right, left, up, down}
    localparam int BTN_W     = 5;
    localparam int BTN_ENTER = 4;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 0;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_DRAW_BOARD,
        ST_INIT_PIECES,
        ST_DRAW_CURSOR,
        ST_IDLE,
        ST_CHECK,
        ST_INVALID,
        ST_PLACE,
        ST_FLIP,
        ST_SCORE,
        ST_QUERY,
        ST_END_UNHL,
        ST_END_WAIT,
        ST_CLEAR
    } state_e;

    function automatic int coord_w(input int board_dim);
        return $clog2(board_dim);
    endfunction

    // Opcode issued on entry to each engine state.
    function automatic logic [3:0] state_op(input state_e st);
        case (st)
            ST_DRAW_BOARD:  return OP_DRAW_BOARD;
            ST_INIT_PIECES: return OP_INIT_PIECES;
            ST_DRAW_CURSOR: return OP_DRAW_CURSOR;
            ST_CHECK:       return OP_CHECK;
            ST_PLACE:       return OP_PLACE;
            ST_FLIP:        return OP_FLIP;
            ST_SCORE:       return OP_SCORE;
            ST_QUERY:       return OP_HASTURN;
            ST_END_UNHL:    return OP_UNHIGHLIGHT;
            ST_CLEAR:       return OP_CLEAR;
            default:        return OP_DRAW_BOARD;
        endcase
    endfunction

    // (p + k) mod n; n need not be a power of two.
    function automatic logic [1:0] player_add(input logic [1:0] p,
                                              input logic [2:0] k,
                                              input int n);
        int sum;
        sum = int'(p) + int'(k);
        return 2'(sum % n);
    endfunction

endpackage

// File: rtl/game_sequencer_btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Registered rising-edge detector for the five level buttons. A press is
// "current high, previous low". If more than one button rises in the same
// cycle the whole vector is dropped, so press_o is either zero or one-hot.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   btn_i        {enter, right, left, up, down} levels, synchronous to clk
//   press_o      single accepted press (one-hot or zero), combinational
// -----------------------------------------------------------------------------
module btn_edge
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [BTN_W-1:0] btn_i,
    output logic [BTN_W-1:0] press_o
);

    logic [BTN_W-1:0] prev_q;
    logic [BTN_W-1:0] prev_d;
    logic [BTN_W-1:0] rise;

    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        prev_d  = btn_i;
        rise    = btn_i & ~prev_q;
        // rise & (rise-1) clears the lowest set bit; zero means at most one bit.
        press_o = ((rise & (rise - BTN_W'(1))) == '0) ? rise : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Board-game control FSM. Sequences board drawing, cursor movement, move
// checking, placement, flipping, scoring and turn hand-over for 2..4 players,
// driving datapath engines through a start/done handshake with an opcode.
// Every engine state pulses eng_start in its first cycle and advances on the
// edge where eng_done=1; eng_done during the start cycle or in non-engine
// states is ignored.
// Configuration macro: GAME_SEQ_CURSOR_WRAP_EN -- when defined the cursor wraps
// around the board edges, otherwise it saturates at 0 and BOARD_DIM-1.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   enter, move_*               level buttons (edge-detected internally)
//   eng_done                    one-cycle completion pulse from the engine
//   valid_move                  CHECK result, sampled with eng_done
//   has_turn                    HASTURN result, sampled with eng_done
//   eng_start, eng_op           request pulse and opcode (held until done)
//   cursor_x, cursor_y          cursor position
//   player, query_player        current player / player under query
//   msg_invalid                 invalid-move message active
//   game_over                   end of game, waiting for enter to restart
// -----------------------------------------------------------------------------
module game_sequencer
    import game_pkg::*;
#(
    parameter int BOARD_DIM  = 8,
    parameter int N_PLAYERS  = 2,
    parameter int MSG_CYCLES = 50000000
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enter,
    input  logic                         move_right,
    input  logic                         move_left,
    input  logic                         move_up,
    input  logic                         move_down,
    input  logic                         eng_done,
    input  logic                         valid_move,
    input  logic                         has_turn,
    output logic                         eng_start,
    output logic [3:0]                   eng_op,
    output logic [$clog2(BOARD_DIM)-1:0] cursor_x,
    output logic [$clog2(BOARD_DIM)-1:0] cursor_y,
    output logic [1:0]                   player,
    output logic [1:0]                   query_player,
    output logic                         msg_invalid,
    output logic                         game_over
);

    localparam int CW = coord_w(BOARD_DIM);
    localparam int TW = $clog2(MSG_CYCLES + 1);
    localparam logic [CW-1:0] C_MAX    = CW'(BOARD_DIM - 1);
    localparam logic [CW-1:0] C_CENTER = CW'(BOARD_DIM / 2 - 1);
    localparam logic [TW-1:0] MSG_LAST = TW'(MSG_CYCLES - 1);

    function automatic logic [CW-1:0] step_inc(input logic [CW-1:0] c);
`ifdef GAME_SEQ_CURSOR_WRAP_EN
        return (c == C_MAX) ? '0 : c + CW'(1);
`else
        return (c == C_MAX) ? C_MAX : c + CW'(1);
`endif
    endfunction

    function automatic logic [CW-1:0] step_dec(input logic [CW-1:0] c);
`ifdef GAME_SEQ_CURSOR_WRAP_EN
        return (c == '0) ? C_MAX : c - CW'(1);
`else
        return (c == '0) ? '0 : c - CW'(1);
`endif
    endfunction

    logic [BTN_W-1:0] press;

    btn_edge u_btn_edge (
        .clk     (clk),
        .resetn  (resetn),
        .btn_i   ({enter, move_right, move_left, move_up, move_down}),
        .press_o (press)
    );

    state_e        state_q,     state_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic [2:0]    k_q,         k_d;
    logic [CW-1:0] cx_q,        cx_d;
    logic [CW-1:0] cy_q,        cy_d;
    logic [1:0]    player_q,    player_d;
    logic [1:0]    qp_q,        qp_d;
    logic          msg_q,       msg_d;
    logic          go_q,        go_d;
    logic          eng_start_q, eng_start_d;
    logic [3:0]    eng_op_q,    eng_op_d;

    logic          launch;     // entering (or re-entering) an engine state
    logic          wait_done;  // engine completion outside the start cycle

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        k_d         = k_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        player_d    = player_q;
        qp_d        = qp_q;
        msg_d       = msg_q;
        go_d        = go_q;
        eng_start_d = 1'b0;
        eng_op_d    = eng_op_q;
        launch      = 1'b0;
        wait_done   = eng_done && !eng_start_q;

        case (state_q)
            ST_INIT: begin
                cx_d     = C_CENTER;
                cy_d     = C_CENTER;
                player_d = '0;
                k_d      = '0;
                state_d  = ST_DRAW_BOARD;
                launch   = 1'b1;
            end
            ST_DRAW_BOARD: if (wait_done) begin
                state_d = ST_INIT_PIECES;
                launch  = 1'b1;
            end
            ST_INIT_PIECES: if (wait_done) begin
                state_d = ST_DRAW_CURSOR;
                launch  = 1'b1;
            end
            ST_DRAW_CURSOR: if (wait_done) begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // press is zero or one-hot, so at most one branch fires.
                if (press[BTN_ENTER]) begin
                    state_d = ST_CHECK;
                    launch  = 1'b1;
                end else if (press != '0) begin
                    if (press[BTN_RIGHT]) cx_d = step_inc(cx_q);
                    if (press[BTN_LEFT])  cx_d = step_dec(cx_q);
                    if (press[BTN_DOWN])  cy_d = step_inc(cy_q);
                    if (press[BTN_UP])    cy_d = step_dec(cy_q);
                    // Blocked moves still redraw.
                    state_d = ST_DRAW_CURSOR;
                    launch  = 1'b1;
                end
            end
            ST_CHECK: if (wait_done) begin
                if (valid_move) begin
                    state_d = ST_PLACE;
                    launch  = 1'b1;
                end else begin
                    state_d = ST_INVALID;
                    timer_d = '0;
                    msg_d   = 1'b1;
                end
            end
            ST_INVALID: begin
                if (timer_q == MSG_LAST) begin
                    timer_d = '0;
                    msg_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_PLACE: if (wait_done) begin
                state_d = ST_FLIP;
                launch  = 1'b1;
            end
            ST_FLIP: if (wait_done) begin
                state_d = ST_SCORE;
                launch  = 1'b1;
            end
            ST_SCORE: if (wait_done) begin
                k_d     = 3'd1;
                qp_d    = player_add(player_q, 3'd1, N_PLAYERS);
                state_d = ST_QUERY;
                launch  = 1'b1;
            end
            ST_QUERY: if (wait_done) begin
                if (has_turn) begin
                    player_d = qp_q;
                    k_d      = '0;
                    state_d  = ST_DRAW_CURSOR;
                end else if (k_q < 3'(N_PLAYERS)) begin
                    k_d  = k_q + 3'd1;
                    qp_d = player_add(player_q, k_q + 3'd1, N_PLAYERS);
                end else begin
                    // k == N_PLAYERS: the current player is blocked too.
                    k_d     = '0;
                    state_d = ST_END_UNHL;
                end
                launch = 1'b1;
            end
            ST_END_UNHL: if (wait_done) begin
                state_d = ST_END_WAIT;
                go_d    = 1'b1;
            end
            ST_END_WAIT: if (press[BTN_ENTER]) begin
                go_d    = 1'b0;
                state_d = ST_CLEAR;
                launch  = 1'b1;
            end
            ST_CLEAR: if (wait_done) begin
                state_d = ST_INIT;
            end
            default: state_d = ST_INIT;
        endcase

        if (launch) begin
            eng_start_d = 1'b1;
            eng_op_d    = state_op(state_d);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_INIT;
            timer_q     <= '0;
            k_q         <= '0;
            cx_q        <= C_CENTER;
            cy_q        <= C_CENTER;
            player_q    <= '0;
            qp_q        <= '0;
            msg_q       <= 1'b0;
            go_q        <= 1'b0;
            eng_start_q <= 1'b0;
            eng_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            k_q         <= k_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            player_q    <= player_d;
            qp_q        <= qp_d;
            msg_q       <= msg_d;
            go_q        <= go_d;
            eng_start_q <= eng_start_d;
            eng_op_q    <= eng_op_d;
        end
    end

    assign eng_start    = eng_start_q;
    assign eng_op       = eng_op_q;
    assign cursor_x     = cx_q;
    assign cursor_y     = cy_q;
    assign player       = player_q;
    assign query_player = qp_q;
    assign msg_invalid  = msg_q;
    assign game_over    = go_q;

endmodule
